riscv_cu: RTL and testbench

//  Multi-cycle control unit for the RV32I core. It fetches and latches an instruction from memory, then decodes it.
//  It sequences FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK and drives register addresses, ALU/branch/LSU ops, immediate type,

---
 rtl/riscv_cu.sv | 172 +++++++++++++++++
 tb/tb_riscv_cu.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_cu.sv
// Multi-cycle RV32I control unit: latches an instruction, decodes it from the IR and
// steps FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK, pulsing the PC, register and store strobes.
module riscv_cu (
   input  logic        CLK,
   input  logic        RST,
   input  logic [31:0] MEM_INST,
   input  logic        INST_ENB,
   input  logic        READ_ENB,
   output logic [4:0]  RS1_ADR,
   output logic [4:0]  RS2_ADR,
   output logic [4:0]  REG_ADR,
   output logic        PC_CLK,
   output logic [3:0]  ALU_OPT,
   output logic [2:0]  BR_OPT,
   output logic [2:0]  LSU_OPT,
   output logic        WRITE_ENB,
   output logic        MEM_WRITE_ENB,
   output logic        GLOBAL_RESET,
   output logic [2:0]  IMM_TYPE,
   output logic [2:0]  RS1_MUX_SELECT,
   output logic [2:0]  RS2_MUX_SELECT,
   output logic [2:0]  REG_MUX_SELECT,
   output logic [2:0]  LSU_MUX_SELECT,
   output logic [2:0]  PC_MUX_SELECT
);
   typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY, S_WRITEBACK} state_t;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_SLL  = 4'd2;
   localparam logic [3:0] ALU_SLT  = 4'd3;
   localparam logic [3:0] ALU_SLTU = 4'd4;
   localparam logic [3:0] ALU_XOR  = 4'd5;
   localparam logic [3:0] ALU_SRL  = 4'd6;
   localparam logic [3:0] ALU_SRA  = 4'd7;
   localparam logic [3:0] ALU_OR   = 4'd8;
   localparam logic [3:0] ALU_AND  = 4'd9;

   localparam logic [31:0] INST_NOP = 32'h0000_0013;

   state_t      state;
   logic [31:0] ir;
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic        alt;
   logic        unused_ir;

   assign opcode    = ir[6:0];
   assign funct3    = ir[14:12];
   assign alt       = ir[30];
   assign unused_ir = ^{ir[31], ir[29:25]};

   logic [3:0] alu_fn, d_alu;
   logic [2:0] d_br, d_lsu, d_imm, d_m1, d_m2, d_mr, d_mp;
   logic       wr_rd, is_load, is_store, rd_write;

   // funct7[5] selects SUB only for register ops; for immediates it only marks SRAI
   always_comb begin
      alu_fn = ALU_ADD;
      case (funct3)
         3'd0: alu_fn = (opcode == OPC_OP && alt) ? ALU_SUB : ALU_ADD;
         3'd1: alu_fn = ALU_SLL;
         3'd2: alu_fn = ALU_SLT;
         3'd3: alu_fn = ALU_SLTU;
         3'd4: alu_fn = ALU_XOR;
         3'd5: alu_fn = alt ? ALU_SRA : ALU_SRL;
         3'd6: alu_fn = ALU_OR;
         default: alu_fn = ALU_AND;
      endcase
   end

   always_comb begin
      d_alu    = ALU_ADD;
      d_br     = 3'd2;
      d_lsu    = 3'd0;
      d_imm    = 3'd0;
      d_m1     = 3'd0;
      d_m2     = 3'd0;
      d_mr     = 3'd0;
      d_mp     = 3'd0;
      wr_rd    = 1'b0;
      is_load  = 1'b0;
      is_store = 1'b0;
      case (opcode)
         OPC_OP:     begin d_alu = alu_fn; wr_rd = 1'b1; end
         OPC_OPIMM:  begin d_alu = alu_fn; d_m2 = 3'd1; d_imm = 3'd1; wr_rd = 1'b1; end
         OPC_LOAD:   begin d_m2 = 3'd1; d_imm = 3'd1; d_mr = 3'd1; d_lsu = funct3;
                           wr_rd = 1'b1; is_load = 1'b1; end
         OPC_STORE:  begin d_m2 = 3'd1; d_imm = 3'd2; d_lsu = funct3; is_store = 1'b1; end
         OPC_BRANCH: begin d_imm = 3'd3; d_br = funct3; d_mp = 3'd1; end
         OPC_LUI:    begin d_imm = 3'd4; d_mr = 3'd3; wr_rd = 1'b1; end
         OPC_AUIPC:  begin d_m1 = 3'd1; d_m2 = 3'd1; d_imm = 3'd4; wr_rd = 1'b1; end
         OPC_JAL:    begin d_imm = 3'd5; d_br = 3'd3; d_mp = 3'd1; d_mr = 3'd2; wr_rd = 1'b1; end
         OPC_JALR:   begin d_m2 = 3'd1; d_imm = 3'd1; d_br = 3'd3; d_mp = 3'd2; d_mr = 3'd2;
                           wr_rd = 1'b1; end
         default:    ;
      endcase
   end

   assign rd_write = wr_rd && (ir[11:7] != 5'd0);

   // While fetching, the IR may still hold the previous instruction, so ops sit at idle
   logic idle;
   assign idle           = (state == S_FETCH);
   assign RS1_ADR        = ir[19:15];
   assign RS2_ADR        = ir[24:20];
   assign REG_ADR        = ir[11:7];
   assign ALU_OPT        = idle ? ALU_ADD : d_alu;
   assign BR_OPT         = idle ? 3'd2    : d_br;
   assign LSU_OPT        = idle ? 3'd0    : d_lsu;
   assign IMM_TYPE       = idle ? 3'd0    : d_imm;
   assign RS1_MUX_SELECT = idle ? 3'd0    : d_m1;
   assign RS2_MUX_SELECT = idle ? 3'd0    : d_m2;
   assign REG_MUX_SELECT = idle ? 3'd0    : d_mr;
   assign PC_MUX_SELECT  = idle ? 3'd0    : d_mp;
   assign LSU_MUX_SELECT = idle ? 3'd1    : 3'd0;

   // Strobes are registered on the transition so they are high during the target state only
   always_ff @(posedge CLK) begin
      if (!RST) begin
         state         <= S_FETCH;
         ir            <= INST_NOP;
         GLOBAL_RESET  <= 1'b1;
         PC_CLK        <= 1'b0;
         WRITE_ENB     <= 1'b0;
         MEM_WRITE_ENB <= 1'b0;
      end else begin
         GLOBAL_RESET  <= 1'b0;
         PC_CLK        <= 1'b0;
         WRITE_ENB     <= 1'b0;
         MEM_WRITE_ENB <= 1'b0;
         case (state)
            S_FETCH: begin
               if (INST_ENB) begin
                  ir    <= MEM_INST;
                  state <= S_DECODE;
               end
            end
            S_DECODE: state <= S_EXECUTE;
            S_EXECUTE: begin
               if (is_load || is_store) begin
                  state         <= S_MEMORY;
                  MEM_WRITE_ENB <= is_store;
               end else begin
                  state     <= S_WRITEBACK;
                  PC_CLK    <= 1'b1;
                  WRITE_ENB <= rd_write;
               end
            end
            S_MEMORY: begin
               if (is_store || READ_ENB) begin
                  state     <= S_WRITEBACK;
                  PC_CLK    <= 1'b1;
                  WRITE_ENB <= rd_write;
               end
            end
            S_WRITEBACK: state <= S_FETCH;
            default:     state <= S_FETCH;
         endcase
      end
   end
endmodule

// File: tb/tb_riscv_cu.sv
// Bench for riscv_cu: directed and random instructions against a table-driven model that
// predicts decode fields and the per-cycle strobe timeline.
module tb_riscv_cu;
   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic [31:0] MEM_INST = 32'h0;
   logic        INST_ENB = 1'b0;
   logic        READ_ENB = 1'b0;
   logic [4:0]  RS1_ADR, RS2_ADR, REG_ADR;
   logic        PC_CLK, WRITE_ENB, MEM_WRITE_ENB, GLOBAL_RESET;
   logic [3:0]  ALU_OPT;
   logic [2:0]  BR_OPT, LSU_OPT, IMM_TYPE;
   logic [2:0]  RS1_MUX_SELECT, RS2_MUX_SELECT, REG_MUX_SELECT, LSU_MUX_SELECT, PC_MUX_SELECT;

   riscv_cu dut (
      .CLK(CLK), .RST(RST), .MEM_INST(MEM_INST), .INST_ENB(INST_ENB), .READ_ENB(READ_ENB),
      .RS1_ADR(RS1_ADR), .RS2_ADR(RS2_ADR), .REG_ADR(REG_ADR), .PC_CLK(PC_CLK),
      .ALU_OPT(ALU_OPT), .BR_OPT(BR_OPT), .LSU_OPT(LSU_OPT), .WRITE_ENB(WRITE_ENB),
      .MEM_WRITE_ENB(MEM_WRITE_ENB), .GLOBAL_RESET(GLOBAL_RESET), .IMM_TYPE(IMM_TYPE),
      .RS1_MUX_SELECT(RS1_MUX_SELECT), .RS2_MUX_SELECT(RS2_MUX_SELECT),
      .REG_MUX_SELECT(REG_MUX_SELECT), .LSU_MUX_SELECT(LSU_MUX_SELECT),
      .PC_MUX_SELECT(PC_MUX_SELECT)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic [3:0] alu;
      logic [2:0] br, lsu, imm, m1, m2, mr, mp;
   } ops_t;

   // strobes PC_CLK, WRITE_ENB, MEM_WRITE_ENB, then LSU mux, then the decoded ops
   typedef struct packed {
      logic [2:0] stb;
      logic [2:0] lsu_mux;
      ops_t       ops;
   } obs_t;

   localparam ops_t IDLE_OPS = '{alu: 4'd0, br: 3'd2, default: 3'd0};

   obs_t obs;
   assign obs = '{stb: {PC_CLK, WRITE_ENB, MEM_WRITE_ENB}, lsu_mux: LSU_MUX_SELECT,
                  ops: '{alu: ALU_OPT, br: BR_OPT, lsu: LSU_OPT, imm: IMM_TYPE,
                         m1: RS1_MUX_SELECT, m2: RS2_MUX_SELECT, mr: REG_MUX_SELECT,
                         mp: PC_MUX_SELECT}};

   int n_pass = 0;
   int n_total = 0;

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // Reference decode, straight from the ISA table
   function automatic void model(input logic [31:0] in, output ops_t o, output bit ld,
                                 output bit st, output bit wr);
      logic [3:0] f3_alu [8];
      logic [2:0] f3;
      f3_alu = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
      f3 = in[14:12];
      o = IDLE_OPS;
      ld = 0; st = 0; wr = 0;
      case (in[6:0])
         7'b0110011: begin
            o.alu = f3_alu[f3];
            if (in[30] && f3 == 3'd0) o.alu = 4'd1;
            if (in[30] && f3 == 3'd5) o.alu = 4'd7;
            wr = 1;
         end
         7'b0010011: begin
            o.alu = f3_alu[f3];
            if (in[30] && f3 == 3'd5) o.alu = 4'd7;
            o.m2 = 1; o.imm = 1; wr = 1;
         end
         7'b0000011: begin o.m2 = 1; o.imm = 1; o.mr = 1; o.lsu = f3; ld = 1; wr = 1; end
         7'b0100011: begin o.m2 = 1; o.imm = 2; o.lsu = f3; st = 1; end
         7'b1100011: begin o.imm = 3; o.br = f3; o.mp = 1; end
         7'b0110111: begin o.imm = 4; o.mr = 3; wr = 1; end
         7'b0010111: begin o.m1 = 1; o.m2 = 1; o.imm = 4; wr = 1; end
         7'b1101111: begin o.imm = 5; o.br = 3; o.mp = 1; o.mr = 2; wr = 1; end
         7'b1100111: begin o.m2 = 1; o.imm = 1; o.br = 3; o.mp = 2; o.mr = 2; wr = 1; end
         default: ;
      endcase
      if (in[11:7] == 5'd0) wr = 0;
   endfunction

   // Drives one instruction through the unit and checks every cycle of its timeline
   task automatic run_inst(input string nm, input logic [31:0] inst, input int fwait,
                           input int lwait);
      ops_t eo;
      bit ld, st, wr;
      obs_t exp_o;
      int mem_cycles;
      model(inst, eo, ld, st, wr);
      for (int i = 0; i <= fwait; i++) begin
         INST_ENB = (i == fwait);
         MEM_INST = (i == fwait) ? inst : $urandom;
         exp_o = '{stb: 3'b000, lsu_mux: 3'd1, ops: IDLE_OPS};
         n_total++;
         if (obs !== exp_o) $display("FAIL %s fetch[%0d]: got %h want %h", nm, i, obs, exp_o);
         else n_pass++;
         step();
      end
      INST_ENB = 1'b0;
      MEM_INST = $urandom;
      mem_cycles = ld ? lwait + 1 : (st ? 1 : 0);
      for (int c = 0; c < 2 + mem_cycles; c++) begin
         if (c >= 2) READ_ENB = ld && (c - 2 == lwait);
         exp_o = '{stb: {2'b00, st && c >= 2}, lsu_mux: 3'd0, ops: eo};
         n_total++;
         if (obs !== exp_o || {RS1_ADR, RS2_ADR, REG_ADR} !== {inst[19:15], inst[24:20], inst[11:7]})
            $display("FAIL %s cyc%0d: got %h/%h want %h/%h", nm, c + 2, obs,
                     {RS1_ADR, RS2_ADR, REG_ADR}, exp_o, {inst[19:15], inst[24:20], inst[11:7]});
         else n_pass++;
         step();
      end
      READ_ENB = 1'b0;
      exp_o = '{stb: {1'b1, wr, 1'b0}, lsu_mux: 3'd0, ops: eo};
      n_total++;
      if (obs !== exp_o) $display("FAIL %s writeback: got %h want %h", nm, obs, exp_o);
      else n_pass++;
      step();
      exp_o = '{stb: 3'b000, lsu_mux: 3'd1, ops: IDLE_OPS};
      n_total++;
      if (obs !== exp_o) $display("FAIL %s refetch: got %h want %h", nm, obs, exp_o);
      else n_pass++;
   endtask

   task automatic test_reset();
      obs_t exp_o;
      RST = 1'b0;
      step();
      step();
      exp_o = '{stb: 3'b000, lsu_mux: 3'd1, ops: IDLE_OPS};
      n_total++;
      if (obs !== exp_o || GLOBAL_RESET !== 1'b1 || {RS1_ADR, RS2_ADR, REG_ADR} !== 15'd0)
         $display("FAIL reset_state: got %h gr=%b adr=%h want %h gr=1 adr=0", obs, GLOBAL_RESET,
                  {RS1_ADR, RS2_ADR, REG_ADR}, exp_o);
      else n_pass++;
      RST = 1'b1;
      step();
      n_total++;
      if (GLOBAL_RESET !== 1'b0) $display("FAIL reset_release: got gr=%b want 0", GLOBAL_RESET);
      else n_pass++;
   endtask

   task automatic test_add();
      run_inst("add", 32'h002081B3, 0, 0);
      run_inst("sub", 32'h402081B3, 1, 0);
      run_inst("srai", 32'h4030D193, 0, 0);
   endtask

   task automatic test_load_stall();
      run_inst("lw_stall", 32'h0080A283, 0, 3);
      run_inst("lbu", 32'h0040C283, 0, 0);
   endtask

   task automatic test_store();
      run_inst("sw", 32'h0020A223, 0, 0);
   endtask

   task automatic test_branch_jump();
      run_inst("beq", 32'h00208463, 0, 0);
      run_inst("jal", 32'h008000EF, 0, 0);
      run_inst("jalr", 32'h000080E7, 0, 0);
      run_inst("lui", 32'h123452B7, 0, 0);
      run_inst("auipc", 32'h00001297, 0, 0);
   endtask

   task automatic test_nop_x0();
      run_inst("addi_x0", 32'h00100013, 5, 0);
      run_inst("unknown", 32'hFFFFFFFF, 0, 0);
   endtask

   task automatic test_reset_abort();
      obs_t exp_o;
      for (int k = 0; k < 2; k++) begin
         INST_ENB = 1'b1;
         MEM_INST = (k == 0) ? 32'h002081B3 : 32'h0020A223;
         step();
         INST_ENB = 1'b0;
         step();
         RST = 1'b0;
         step();
         exp_o = '{stb: 3'b000, lsu_mux: 3'd1, ops: IDLE_OPS};
         n_total++;
         if (obs !== exp_o || GLOBAL_RESET !== 1'b1)
            $display("FAIL abort%0d: got %h gr=%b want %h gr=1", k, obs, GLOBAL_RESET, exp_o);
         else n_pass++;
         RST = 1'b1;
         step();
         n_total++;
         if (obs !== exp_o || GLOBAL_RESET !== 1'b0)
            $display("FAIL abort%0d_release: got %h gr=%b want %h gr=0", k, obs, GLOBAL_RESET, exp_o);
         else n_pass++;
      end
      run_inst("after_abort", 32'h002081B3, 0, 0);
   endtask

   task automatic test_random();
      logic [6:0] opc [12];
      logic [31:0] r;
      opc = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b0110111,
              7'b0010111, 7'b1101111, 7'b1100111, 7'b0001111, 7'b1110011, 7'b1111111};
      for (int n = 0; n < 40; n++) begin
         r = $urandom;
         run_inst($sformatf("rand%0d", n), {r[31:7], opc[$urandom_range(0, 11)]},
                  $urandom_range(0, 2), $urandom_range(0, 3));
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_load_stall();
      test_store();
      test_branch_jump();
      test_nop_x0();
      test_reset_abort();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
